// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types and constants for the continuous monitoring system.
//
// Contents:
//   RISC_V_INSTRUCTION_WIDTH : width of a traced instruction word
//   DEFAULT_PC_WIDTH         : default program-counter width
//   TRACE_ITEM_WIDTH         : width of one {instr, pc} trace item at the default PC width
//   trace_buffer_state_t     : trace buffer control states (RUN, DRAIN, HALTED)
package continuous_monitoring_system_pkg;

  localparam int RISC_V_INSTRUCTION_WIDTH = 32;
  localparam int DEFAULT_PC_WIDTH         = 64;
  localparam int TRACE_ITEM_WIDTH         = DEFAULT_PC_WIDTH + RISC_V_INSTRUCTION_WIDTH;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } trace_buffer_state_t;

endpackage

// File: rtl/trace_buffer_if.sv
// Streaming output bundle of the trace buffer.
//
// Signals:
//   m_tdata  : {instr, pc} of the head entry
//   m_tvalid : head entry is available
//   m_tready : consumer accepts the head entry
//   m_tlast  : head entry is the final entry of a drain
// Modports:
//   master : the trace buffer (drives data/valid/last, samples ready)
//   slave  : the consumer
interface trace_buffer_if
  import continuous_monitoring_system_pkg::*;
#(
  parameter int PC_WIDTH = DEFAULT_PC_WIDTH
) ();

  logic [PC_WIDTH+RISC_V_INSTRUCTION_WIDTH-1:0] m_tdata;
  logic                                         m_tvalid;
  logic                                         m_tready;
  logic                                         m_tlast;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );

endinterface

// File: rtl/trace_fifo_mem.sv
// Trace storage: DEPTH x WIDTH memory, one synchronous write port and one
// asynchronous read port. Contents are never reset.
//
// Ports:
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : read data (combinational from rd_addr)
module trace_fifo_mem
  import continuous_monitoring_system_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = TRACE_ITEM_WIDTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/trace_buffer.sv
// Instruction trace buffer: filtered (pc, instr) captures go into a
// first-word-fall-through FIFO read out over a valid/ready stream. A halt
// pulse drains the FIFO (marking the final entry with m_tlast) and then stops
// capture until a resume pulse.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   pc_valid, pc, instr: trace item and its valid strobe
//   drop_instr         : filter drops this item
//   halt, resume       : drain-then-stop request, restart request
//   m_axis             : output stream (trace_buffer_if.master)
//   fill_level         : current occupancy
//   overflow           : sticky, set when a capture was lost
//   lost_count         : lost-capture counter, only when
//                        TRACE_BUFFER_LOST_COUNTER_EN is defined
module trace_buffer
  import continuous_monitoring_system_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int PC_WIDTH = DEFAULT_PC_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                pc_valid,
  input  logic [PC_WIDTH-1:0]                 pc,
  input  logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr,
  input  logic                                drop_instr,
  input  logic                                halt,
  input  logic                                resume,
  trace_buffer_if.master                      m_axis,
  output logic [$clog2(DEPTH):0]              fill_level,
  output logic                                overflow
`ifdef TRACE_BUFFER_LOST_COUNTER_EN
  ,
  output logic [31:0]                         lost_count
`endif
);

  localparam int AW     = $clog2(DEPTH);
  localparam int ITEM_W = PC_WIDTH + RISC_V_INSTRUCTION_WIDTH;

  trace_buffer_state_t state;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [ITEM_W-1:0] rd_data;
  logic              tvalid;
  logic              tlast;
  logic              full;
  logic              pop;
  logic              push_req;
  logic              push_ok;
  logic              push_lost;

  assign fill_level = wr_ptr - rd_ptr;
  assign full       = (fill_level == (AW+1)'(DEPTH));
  assign tvalid     = (fill_level != '0);
  assign tlast      = (state == DRAIN) && (fill_level == (AW+1)'(1));
  assign pop        = tvalid && m_axis.m_tready;

  // A capture in the halt cycle is ignored, so halt masks the push request.
  assign push_req  = pc_valid && !drop_instr && (state == RUN) && !halt;
  // When full, the incoming item only fits if the head leaves this cycle.
  assign push_ok   = push_req && (!full || pop);
  assign push_lost = push_req && full && !pop;

  assign m_axis.m_tvalid = tvalid;
  assign m_axis.m_tdata  = rd_data;
  assign m_axis.m_tlast  = tlast;

  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ITEM_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({instr, pc}),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      state    <= RUN;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (push_lost) begin
        overflow <= 1'b1;
      end
      unique case (state)
        RUN: begin
          if (halt) begin
            state <= tvalid ? DRAIN : HALTED;
          end
        end
        // The empty check covers a halt that coincided with the pop of the
        // only entry: no entry would ever carry m_tlast, so leave directly.
        DRAIN: begin
          if ((pop && tlast) || !tvalid) begin
            state <= HALTED;
          end
        end
        // halt wins over a simultaneous resume, and halt is ignored here.
        HALTED: begin
          if (resume && !halt) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef TRACE_BUFFER_LOST_COUNTER_EN
  logic resume_accept;

  assign resume_accept = (state == HALTED) && resume && !halt;

  // Saturating count of lost captures, restarted when capture resumes.
  always_ff @(posedge clk) begin
    if (rst || resume_accept) begin
      lost_count <= '0;
    end else if (push_lost && (lost_count != 32'hFFFF_FFFF)) begin
      lost_count <= lost_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trace_buffer.sv
// Directed self-checking bench for trace_buffer (DEPTH=16, PC_WIDTH=64).
module tb_trace_buffer;
  import continuous_monitoring_system_pkg::*;

  localparam int DEPTH    = 16;
  localparam int PC_WIDTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid;
  logic [63:0] pc;
  logic [31:0] instr;
  logic        drop_instr;
  logic        halt;
  logic        resume;
  logic [4:0]  fill_level;
  logic        overflow;
`ifdef TRACE_BUFFER_LOST_COUNTER_EN
  logic [31:0] lost_count;
`endif

  int compared   = 0;
  int mismatched = 0;

  trace_buffer_if #(.PC_WIDTH(PC_WIDTH)) m_axis ();

  trace_buffer #(
    .DEPTH    (DEPTH),
    .PC_WIDTH (PC_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_valid   (pc_valid),
    .pc         (pc),
    .instr      (instr),
    .drop_instr (drop_instr),
    .halt       (halt),
    .resume     (resume),
    .m_axis     (m_axis),
    .fill_level (fill_level),
    .overflow   (overflow)
`ifdef TRACE_BUFFER_LOST_COUNTER_EN
    ,
    .lost_count (lost_count)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] observed,
                       input logic [127:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [95:0] item(input logic [63:0] p, input logic [31:0] i);
    return {i, p};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    pc_valid        = 1'b0;
    pc              = '0;
    instr           = '0;
    drop_instr      = 1'b0;
    halt            = 1'b0;
    resume          = 1'b0;
    m_axis.m_tready = 1'b0;
    @(negedge clk);
    tick();

    // Reset state
    check("rst_fill", 128'(fill_level), 128'(0));
    check("rst_tvalid", 128'(m_axis.m_tvalid), 128'(0));
    check("rst_tlast", 128'(m_axis.m_tlast), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    check("rst_state", 128'(dut.state), 128'(RUN));
    rst = 1'b0;

    // Basic push then pop
    pc_valid = 1'b1; pc = 64'h1000; instr = 32'h0000_0063;
    m_axis.m_tready = 1'b1;
    tick();
    pc_valid = 1'b0;
    check("basic_tvalid", 128'(m_axis.m_tvalid), 128'(1));
    check("basic_tdata", 128'(m_axis.m_tdata), 128'({32'h0000_0063, 64'h1000}));
    check("basic_fill1", 128'(fill_level), 128'(1));
    tick();
    check("basic_fill0", 128'(fill_level), 128'(0));
    check("basic_tvalid0", 128'(m_axis.m_tvalid), 128'(0));

    // Dropped items never enter the FIFO
    pc_valid = 1'b1; drop_instr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pc = 64'h1100 + 64'(i);
      tick();
      check("drop_tvalid", 128'(m_axis.m_tvalid), 128'(0));
    end
    pc_valid = 1'b0; drop_instr = 1'b0;
    check("drop_fill", 128'(fill_level), 128'(0));

    // Overflow: 20 pushes into 16 entries with no consumer
    m_axis.m_tready = 1'b0;
    pc_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pc = 64'h2000 + 64'(i); instr = 32'h100 + 32'(i);
      tick();
    end
    pc_valid = 1'b0;
    check("ovf_fill", 128'(fill_level), 128'(16));
    check("ovf_flag", 128'(overflow), 128'(1));
`ifdef TRACE_BUFFER_LOST_COUNTER_EN
    check("ovf_lost_count", 128'(lost_count), 128'(4));
`endif
    m_axis.m_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_order", 128'(m_axis.m_tdata),
            128'(item(64'h2000 + 64'(i), 32'h100 + 32'(i))));
      tick();
    end
    check("ovf_empty", 128'(fill_level), 128'(0));

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_overflow", 128'(overflow), 128'(0));

    // Full boundary: push and pop in the same cycle while full
    m_axis.m_tready = 1'b0;
    pc_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pc = 64'h3000 + 64'(i); instr = 32'h200 + 32'(i);
      tick();
    end
    check("full_fill", 128'(fill_level), 128'(16));
    check("full_overflow0", 128'(overflow), 128'(0));
    pc = 64'h3FFF; instr = 32'h2FF;
    m_axis.m_tready = 1'b1;
    tick();
    pc_valid = 1'b0;
    check("full_pp_fill", 128'(fill_level), 128'(16));
    check("full_pp_overflow", 128'(overflow), 128'(0));
    for (int i = 1; i < 16; i++) begin
      check("full_order", 128'(m_axis.m_tdata),
            128'(item(64'h3000 + 64'(i), 32'h200 + 32'(i))));
      tick();
    end
    check("full_last_entry", 128'(m_axis.m_tdata), 128'(item(64'h3FFF, 32'h2FF)));
    tick();
    check("full_empty", 128'(fill_level), 128'(0));

    // Drain: 3 entries, halt, capture attempts continue throughout
    m_axis.m_tready = 1'b0;
    pc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 64'h4000 + 64'(i); instr = 32'h300 + 32'(i);
      tick();
    end
    pc = 64'h4FFF; instr = 32'h3FF; halt = 1'b1;
    tick();
    halt = 1'b0; pc = 64'h4AAA; instr = 32'h3AA;
    check("drain_state", 128'(dut.state), 128'(DRAIN));
    check("drain_fill", 128'(fill_level), 128'(3));
    check("drain_tlast_early", 128'(m_axis.m_tlast), 128'(0));
    m_axis.m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain_data", 128'(m_axis.m_tdata),
            128'(item(64'h4000 + 64'(i), 32'h300 + 32'(i))));
      check("drain_tlast", 128'(m_axis.m_tlast), 128'(i == 2));
      tick();
    end
    check("drain_halted", 128'(dut.state), 128'(HALTED));
    check("drain_tvalid0", 128'(m_axis.m_tvalid), 128'(0));
    tick();
    tick();
    check("halted_ignore", 128'(fill_level), 128'(0));
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_state", 128'(dut.state), 128'(RUN));
    check("resume_fill", 128'(fill_level), 128'(0));
    m_axis.m_tready = 1'b0;
    pc = 64'h5001; instr = 32'h401;
    tick();
    pc_valid = 1'b0;
    check("resume_capture_fill", 128'(fill_level), 128'(1));
    check("resume_capture_data", 128'(m_axis.m_tdata), 128'(item(64'h5001, 32'h401)));
    m_axis.m_tready = 1'b1;
    tick();
    check("resume_pop", 128'(fill_level), 128'(0));

    // Halt on empty, with a simultaneous resume that must lose
    halt = 1'b1; resume = 1'b1;
    tick();
    halt = 1'b0; resume = 1'b0;
    check("empty_halt_state", 128'(dut.state), 128'(HALTED));
    check("empty_halt_tvalid", 128'(m_axis.m_tvalid), 128'(0));
    pc_valid = 1'b1; pc = 64'h5500;
    tick();
    pc_valid = 1'b0;
    check("empty_halt_ignore", 128'(fill_level), 128'(0));
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("empty_resume_state", 128'(dut.state), 128'(RUN));

    // Reset in the middle of a drain
    m_axis.m_tready = 1'b0;
    pc_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc = 64'h6000 + 64'(i); instr = 32'h500 + 32'(i);
      tick();
    end
    pc_valid = 1'b0;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("mid_drain_state", 128'(dut.state), 128'(DRAIN));
    check("mid_drain_fill", 128'(fill_level), 128'(5));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_fill", 128'(fill_level), 128'(0));
    check("mid_rst_state", 128'(dut.state), 128'(RUN));
    check("mid_rst_tlast", 128'(m_axis.m_tlast), 128'(0));
    check("mid_rst_tvalid", 128'(m_axis.m_tvalid), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
